// File: rtl/alu_seq_md.sv
// Handshaked ALU: single-cycle basic ops and iterative (one bit per cycle)
// shift-add multiply and restoring divide, with registered result and flags.
module alu_seq_md #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic [3:0]       ALUControl,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] Result,
    output logic             Zero,
    output logic             Negative,
    output logic             Carry,
    output logic             Overflow,
    output logic             Illegal
);

    localparam int CW = $clog2(WIDTH + 1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t             state_reg, state_next;
    logic [2:0]         op_reg;
    logic [WIDTH-1:0]   opnd_reg;
    logic [2*WIDTH-1:0] acc_reg;
    logic [CW-1:0]      count_reg;
    logic               neg_q_reg, neg_r_reg;

    logic [WIDTH:0]     add_sum, sub_sum, mul_sum, div_sh;
    logic [WIDTH-1:0]   div_diff, abs_a, abs_b, res_next, iter_res;
    logic               div_ge, carry_next, ovf_next, illegal_next, is_iter;
    logic               load_nq, load_nr;
    logic [2*WIDTH-1:0] load_acc, step_next;
    logic [WIDTH-1:0]   load_opnd;

    assign in_ready  = rst && (state_reg == IDLE);
    assign out_valid = (state_reg == DONE);

    // Decode of the request presented at the inputs: either a finished
    // result (basic ops, illegal codes, divide corner cases) or the
    // initial iteration state for multiply/divide.
    always_comb begin
        add_sum      = {1'b0, A} + {1'b0, B};
        sub_sum      = {1'b0, A} + {1'b0, ~B} + {{WIDTH{1'b0}}, 1'b1};
        abs_a        = A[WIDTH-1] ? -A : A;
        abs_b        = B[WIDTH-1] ? -B : B;
        res_next     = '0;
        carry_next   = 1'b0;
        ovf_next     = 1'b0;
        illegal_next = 1'b0;
        is_iter      = 1'b0;
        load_acc     = {{WIDTH{1'b0}}, B};
        load_opnd    = A;
        load_nq      = 1'b0;
        load_nr      = 1'b0;
        case (ALUControl)
            4'b0000: begin
                res_next   = add_sum[WIDTH-1:0];
                carry_next = add_sum[WIDTH];
                ovf_next   = (A[WIDTH-1] == B[WIDTH-1]) && (add_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0001: begin
                res_next   = sub_sum[WIDTH-1:0];
                carry_next = sub_sum[WIDTH];
                ovf_next   = (A[WIDTH-1] != B[WIDTH-1]) && (sub_sum[WIDTH-1] != A[WIDTH-1]);
            end
            4'b0010: res_next = A & B;
            4'b0011: res_next = A | B;
            4'b0101: res_next = {{(WIDTH-1){1'b0}}, $signed(A) < $signed(B)};
            4'b1000, 4'b1001: is_iter = 1'b1;
            4'b1100, 4'b1101, 4'b1110, 4'b1111: begin
                if (B == '0) begin
                    res_next = ALUControl[1] ? A : '1;
                end else if (!ALUControl[0] && A == MIN_NEG && B == '1) begin
                    res_next = ALUControl[1] ? '0 : A;
                end else begin
                    is_iter = 1'b1;
                    if (!ALUControl[0]) begin
                        load_acc  = {{WIDTH{1'b0}}, abs_a};
                        load_opnd = abs_b;
                        load_nq   = A[WIDTH-1] ^ B[WIDTH-1];
                        load_nr   = A[WIDTH-1];
                    end else begin
                        load_acc  = {{WIDTH{1'b0}}, A};
                        load_opnd = B;
                    end
                end
            end
            default: illegal_next = 1'b1;
        endcase
    end

    // One iteration step; acc holds {partial product, multiplier} for MUL
    // and {partial remainder, dividend/quotient} for DIV.
    always_comb begin
        mul_sum  = {1'b0, acc_reg[2*WIDTH-1:WIDTH]} + (acc_reg[0] ? {1'b0, opnd_reg} : '0);
        div_sh   = acc_reg[2*WIDTH-1:WIDTH-1];
        div_ge   = div_sh >= {1'b0, opnd_reg};
        div_diff = div_sh[WIDTH-1:0] - opnd_reg;
        if (op_reg[2]) begin
            step_next = {(div_ge ? div_diff : div_sh[WIDTH-1:0]), acc_reg[WIDTH-2:0], div_ge};
        end else begin
            step_next = {mul_sum, acc_reg[WIDTH-1:1]};
        end
        if (!op_reg[2]) begin
            iter_res = op_reg[0] ? step_next[2*WIDTH-1:WIDTH] : step_next[WIDTH-1:0];
        end else if (op_reg[1]) begin
            iter_res = neg_r_reg ? -step_next[2*WIDTH-1:WIDTH] : step_next[2*WIDTH-1:WIDTH];
        end else begin
            iter_res = neg_q_reg ? -step_next[WIDTH-1:0] : step_next[WIDTH-1:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (in_valid) state_next = is_iter ? BUSY : DONE;
            BUSY:    if (count_reg == CW'(1)) state_next = DONE;
            DONE:    if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst) state_reg <= IDLE;
        else      state_reg <= state_next;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            op_reg    <= '0;
            opnd_reg  <= '0;
            acc_reg   <= '0;
            count_reg <= '0;
            neg_q_reg <= 1'b0;
            neg_r_reg <= 1'b0;
            Result    <= '0;
            Zero      <= 1'b0;
            Negative  <= 1'b0;
            Carry     <= 1'b0;
            Overflow  <= 1'b0;
            Illegal   <= 1'b0;
        end else if (state_reg == IDLE && in_valid) begin
            op_reg    <= ALUControl[2:0];
            opnd_reg  <= load_opnd;
            acc_reg   <= load_acc;
            count_reg <= CW'(WIDTH);
            neg_q_reg <= load_nq;
            neg_r_reg <= load_nr;
            if (!is_iter) begin
                Result   <= res_next;
                Zero     <= (res_next == '0);
                Negative <= res_next[WIDTH-1];
                Carry    <= carry_next;
                Overflow <= ovf_next;
                Illegal  <= illegal_next;
            end
        end else if (state_reg == BUSY) begin
            acc_reg   <= step_next;
            count_reg <= count_reg - CW'(1);
            if (count_reg == CW'(1)) begin
                Result   <= iter_res;
                Zero     <= (iter_res == '0);
                Negative <= iter_res[WIDTH-1];
                Carry    <= 1'b0;
                Overflow <= 1'b0;
                Illegal  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_alu_seq_md.sv
// Randomized and directed checks of alu_seq_md against an arithmetic
// reference model of the opcode set, latency and handshake.
module tb_alu_seq_md;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic [3:0]  ALUControl = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] Result;
    logic        Zero, Negative, Carry, Overflow, Illegal;

    int n_checks = 0;
    int n_pass   = 0;

    alu_seq_md #(.WIDTH(32)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .A(A), .B(B), .ALUControl(ALUControl), .out_valid(out_valid),
        .out_ready(out_ready), .Result(Result), .Zero(Zero),
        .Negative(Negative), .Carry(Carry), .Overflow(Overflow),
        .Illegal(Illegal)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    function automatic bit out_of_range(input longint x);
        longint lim = 64'sd2147483647;
        return (x > lim) || (x < -lim - 1);
    endfunction

    // Expected result, flags {Zero,Negative,Carry,Overflow,Illegal} and
    // whether the op takes the long (iterative) path.
    function automatic void model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] r, output logic [4:0] fl, output bit iter);
        longint sa, sb;
        logic [63:0] p;
        logic c, v, ill;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        p = {32'b0, a} * {32'b0, b};
        r = '0; c = 1'b0; v = 1'b0; ill = 1'b0; iter = 1'b0;
        case (op)
            4'd0: begin r = a + b; c = ({32'b0, a} + {32'b0, b}) > 64'hFFFF_FFFF; v = out_of_range(sa + sb); end
            4'd1: begin r = a - b; c = (a >= b); v = out_of_range(sa - sb); end
            4'd2: r = a & b;
            4'd3: r = a | b;
            4'd5: r = (sa < sb) ? 32'd1 : 32'd0;
            4'd8: begin r = p[31:0]; iter = 1'b1; end
            4'd9: begin r = p[63:32]; iter = 1'b1; end
            4'd12: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = a;
                else begin r = 32'(sa / sb); iter = 1'b1; end
            end
            4'd13: begin
                if (b == 0) r = 32'hFFFF_FFFF;
                else begin r = a / b; iter = 1'b1; end
            end
            4'd14: begin
                if (b == 0) r = a;
                else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) r = 32'd0;
                else begin r = 32'(sa % sb); iter = 1'b1; end
            end
            4'd15: begin
                if (b == 0) r = a;
                else begin r = a % b; iter = 1'b1; end
            end
            default: ill = 1'b1;
        endcase
        fl = {(r == 0), r[31], c, v, ill};
    endfunction

    task automatic run_op(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b, input int hold);
        int lat, wait_n;
        bit rdy_seen, iter;
        logic [31:0] er;
        logic [4:0] ef;
        wait_n = 0;
        while (!in_ready && wait_n < 100) begin
            @(posedge clk); #1; wait_n++;
        end
        check("in_ready_idle", 64'(in_ready), 64'd1);
        model(op, a, b, er, ef, iter);
        @(negedge clk);
        A = a; B = b; ALUControl = op; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; A = $urandom; B = $urandom; ALUControl = 4'($urandom);
        lat = 1; rdy_seen = 1'b0;
        while (!out_valid && lat < 200) begin
            if (in_ready) rdy_seen = 1'b1;
            @(posedge clk); #1; lat++;
        end
        check("latency", 64'(lat), iter ? 64'd33 : 64'd1);
        check("no_ready_busy", 64'(rdy_seen), 64'd0);
        check("result", 64'(Result), 64'(er));
        check("flags", 64'({Zero, Negative, Carry, Overflow, Illegal}), 64'(ef));
        $display("op=%b a=%h b=%h result=%h flags=%b latency=%0d", op, a, b, Result,
                 {Zero, Negative, Carry, Overflow, Illegal}, lat);
        for (int i = 0; i < hold; i++) begin
            @(negedge clk);
            in_valid = 1'b1; ALUControl = 4'b0000; A = $urandom; B = $urandom;
            @(posedge clk); #1;
            check("hold_result", 64'(Result), 64'(er));
            check("hold_flags", 64'({Zero, Negative, Carry, Overflow, Illegal}), 64'(ef));
            check("hold_handshake", 64'({out_valid, in_ready}), 64'b10);
        end
        @(negedge clk);
        out_ready = 1'b1; in_valid = (hold > 0);
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b0;
        check("release", 64'({out_valid, in_ready}), 64'b01);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'hFFFF_FFFF;
            2: return 32'h8000_0000;
            3: return 32'($urandom_range(0, 9));
            default: return $urandom;
        endcase
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        bit early_valid;
        repeat (3) @(posedge clk);
        #1;
        check("reset_in_ready", 64'(in_ready), 64'd0);
        check("reset_out_valid", 64'(out_valid), 64'd0);
        check("reset_result", 64'(Result), 64'd0);
        check("reset_flags", 64'({Zero, Negative, Carry, Overflow, Illegal}), 64'd0);
        @(negedge clk); rst = 1'b1; #1;
        check("release_in_ready", 64'(in_ready), 64'd1);

        run_op(4'b0000, 32'h7FFF_FFFF, 32'h0000_0001, 0);
        run_op(4'b0001, 32'd5, 32'd5, 0);
        run_op(4'b0001, 32'd3, 32'd5, 5);
        run_op(4'b1000, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'b1001, 32'h0001_0000, 32'h0001_0000, 0);
        run_op(4'b1100, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'b1110, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(4'b1101, 32'd7, 32'd0, 0);
        run_op(4'b1111, 32'd7, 32'd0, 0);
        run_op(4'b1100, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'b1110, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        run_op(4'b0110, 32'd12, 32'd34, 2);

        for (int i = 0; i < 40; i++) begin
            run_op(4'($urandom_range(0, 15)), pick(), pick(), (i % 8 == 0) ? 2 : 0);
        end

        // Abort an in-flight multiply with reset.
        run_op(4'b0000, 32'd1, 32'd1, 0);
        @(negedge clk);
        A = 32'h1234_5678; B = 32'h9ABC_DEF0; ALUControl = 4'b1000; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (10) @(posedge clk);
        #1;
        check("busy_handshake", 64'({out_valid, in_ready}), 64'b00);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        check("abort_out_valid", 64'(out_valid), 64'd0);
        check("abort_result", 64'(Result), 64'd0);
        check("abort_flags", 64'({Zero, Negative, Carry, Overflow, Illegal}), 64'd0);
        check("abort_in_ready", 64'(in_ready), 64'd0);
        @(negedge clk); rst = 1'b1; #1;
        check("abort_release_ready", 64'(in_ready), 64'd1);
        early_valid = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (out_valid) early_valid = 1'b1;
        end
        check("abort_no_output", 64'(early_valid), 64'd0);
        $display("aborted multiply: out_valid_seen=%0d", early_valid);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_seq_md.md
Name: alu_seq_md

Overview:
- Parametrised, handshaked successor to the core's single-cycle ALU.
- Covers ADD/SUB/AND/OR/SLT with registered status flags, plus RV32M-style multiply and divide.
- Multiply and divide are computed iteratively, one bit per cycle.
- Sits between the decode/register-read stage and writeback of the multi-cycle core; the control unit stalls on in_ready/out_valid.

Parameters:
- WIDTH, 32, operand/result width in bits (minimum 4); also the iteration count for MUL/DIV.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  synchronous, active-low reset
- in_valid  input  1  operation request
- in_ready  output  1  block can accept a request
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- ALUControl  input  4  opcode, captured on accept
- out_valid  output  1  Result and flags are valid
- out_ready  input  1  consumer takes result
- Result  output  WIDTH  registered result
- Zero  output  1  Result == 0
- Negative  output  1  Result[WIDTH-1]
- Carry  output  1  ADD: carry-out; SUB: carry-out of A+~B+1 (1 when A >= B unsigned); 0 for all other ops
- Overflow  output  1  signed overflow for ADD/SUB; 0 for all other ops
- Illegal  output  1  opcode not in the encoding list

Behaviour:
- Opcode encoding:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0101 SLT (signed, result 0/1)
  - 1000 MUL (low WIDTH bits of the product), 1001 MULHU (high WIDTH bits, unsigned)
  - 1100 DIV, 1101 DIVU, 1110 REM, 1111 REMU
  - Any other code: Illegal=1, Result=0, Zero=1, other flags 0.
- Reset (rst=0 at a clock edge):
  - State forced to IDLE; out_valid=0, Result=0, all flags 0, Illegal=0.
  - Any in-flight operation is aborted with no output.
  - in_ready is 0 while rst=0 and 1 in the first cycle after release.
- States:
  - IDLE: in_ready=1.
  - BUSY: in_ready=0, out_valid=0.
  - DONE: in_ready=0, out_valid=1; all outputs held stable.
- Transitions:
  - IDLE with in_valid=1: capture A, B and ALUControl (the accept).
    - Basic ops, illegal codes and MUL/DIV special cases go directly to DONE.
    - All other MUL/DIV ops go to BUSY with iteration counter = WIDTH.
  - BUSY: counter decrements each cycle; go to DONE on the cycle the counter reaches 1.
  - DONE with out_ready=1: go to IDLE. A new request cannot be accepted in that same cycle.
- Latency, with the accept edge at cycle N:
  - Basic ops, illegal codes and special cases: out_valid=1 at N+1.
  - Iterative ops: out_valid=1 at N+WIDTH+1.
- Multiply: unsigned shift-add with a 2*WIDTH accumulator. MUL takes the low half, MULHU the high half.
- Divide: unsigned restoring division, one quotient bit per cycle.
  - DIV/REM divide |A| by |B|.
  - Quotient is negated when the operand signs differ; remainder takes the sign of A.
- Divide special cases (1-cycle latency):
  - B=0: DIVU gives all ones; DIV gives all ones (-1); REMU and REM give A.
  - DIV with A = most-negative and B = all ones: Result = A. REM with the same operands: Result = 0.
- Flags:
  - Zero and Negative are derived from the final Result for every op.
  - Flags are registered together with Result and change only on entry to DONE or on reset.
- Input rules:
  - in_valid while not in IDLE is ignored; the requester must hold its request.
  - A, B and ALUControl are don't-care after the accept.

Test Plan:
- Signed overflow: reset then ADD 0x7FFFFFFF + 0x00000001 → 1 cycle later Result=0x80000000, Negative=1, Overflow=1, Carry=0, Zero=0.
- Zero and borrow flags: SUB 5 - 5 → Result=0, Zero=1, Carry=1; then SUB 3 - 5 → Result=0xFFFFFFFE, Carry=0, Negative=1.
- Multiply latency: MUL then MULHU with 0x00010000 × 0x00010000 → Result=0x00000000 and then 0x00000001. Each out_valid appears exactly 33 cycles after its accept; in_ready=0 throughout.
- Signed divide: DIV and REM with -7 and 2 → 0xFFFFFFFD and 0xFFFFFFFF, 33-cycle latency.
- Divide special cases: DIVU 7/0 → 0xFFFFFFFF; REMU 7/0 → 7; DIV 0x80000000 / 0xFFFFFFFF → 0x80000000; REM of the same → 0. All at 1-cycle latency.
- Backpressure, reset and illegal code:
  - Hold out_ready=0 for 5 cycles in DONE → Result and flags stable; in_valid pulses are ignored.
  - Assert rst=0 mid-BUSY → next cycle out_valid=0, Result=0; after release in_ready=1.
  - Opcode 0110 → Illegal=1, Result=0, Zero=1.
